// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: write-side controller for the camera frame buffer.
// It pairs the RGB565 bytes of each pixel, reduces the pair to RGB111 and
// writes the result to consecutive frame-buffer addresses. Frames are
// delimited by VSYNC, lines by HREF, and capture is single-shot or continuous.
//
// Write port: regwrite is a one-cycle valid for {addr_in, data_in}. There is
// no ready; the RAM takes every write. addr_in/data_in hold between writes.
module cam_capture_ctrl #(
  parameter int AW      = 15,
  parameter int DW      = 3,
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic          cam_byte_en,
  input  logic [7:0]    cam_data,
  input  logic          start,
  input  logic          continuous,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow,
  output logic          line_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VS    = 3'd1,
    WAIT_FRAME = 3'd2,
    CAPTURE    = 3'd3,
    DONE       = 3'd4
  } state_t;

  // One extra bit so the pixel counter can hold the value H_PIX*V_LINES
  // without wrapping back into address 0.
  localparam logic [AW:0] TOTAL    = (AW+1)'(H_PIX * V_LINES);
  localparam logic [AW:0] LINE_LEN = (AW+1)'(H_PIX);

  state_t      state;
  state_t      next_state;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [AW:0] pix_cnt;
  logic [AW:0] line_cnt;
  logic        href_q;
  logic        in_cap;
  logic        href_fall;

  assign in_cap    = (state == CAPTURE);
  assign href_fall = in_cap && href_q && !cam_href;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: capture always begins on a VSYNC high->low boundary.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (start || continuous) next_state = WAIT_VS;
      WAIT_VS:    if (cam_vsync)           next_state = WAIT_FRAME;
      WAIT_FRAME: if (!cam_vsync)          next_state = CAPTURE;
      CAPTURE:    if (cam_vsync)           next_state = DONE;
      DONE:       next_state = continuous ? WAIT_FRAME : IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      busy       <= (next_state != IDLE);
      frame_done <= (next_state == DONE);
    end
  end

  // Byte pairing, pixel write, address counting and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 1'b0;
      hi_byte  <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      href_q   <= 1'b0;
      regwrite <= 1'b0;
      addr_in  <= '0;
      data_in  <= '0;
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else begin
      regwrite <= 1'b0;
      href_q   <= cam_href;

      if (state == IDLE && start) begin
        overflow <= 1'b0;
        line_err <= 1'b0;
      end

      if (!in_cap) begin
        // Outside CAPTURE bytes are ignored and every counter restarts.
        phase    <= 1'b0;
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else begin
        if (!cam_href) begin
          // A dangling hi byte is dropped when the line ends.
          phase    <= 1'b0;
          line_cnt <= '0;
        end else if (cam_byte_en) begin
          phase <= ~phase;
          if (!phase) begin
            hi_byte <= cam_data;
          end else begin
            if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
            if (pix_cnt < TOTAL) begin
              regwrite <= 1'b1;
              addr_in  <= pix_cnt[AW-1:0];
              data_in  <= DW'({hi_byte[7], hi_byte[2], cam_data[4]});
              pix_cnt  <= pix_cnt + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end

        if (href_fall && line_cnt != LINE_LEN) line_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cam_capture_ctrl.md
# cam_capture_ctrl

Write-side controller for the camera frame buffer. It samples the camera pixel bus in the system clock domain and packs two RGB565 bytes into one RGB111 pixel. It generates linear write addresses, data and write enable for the frame-buffer RAM. Frames are delimited by VSYNC/HREF, and the block supports single-shot and continuous capture.

## Interface
- AW, 15, write-address width; must satisfy H_PIX*V_LINES <= 2**AW
- DW, 3, pixel width written to RAM ({R,G,B}, 1 bit each)
- H_PIX, 160, pixels per line
- V_LINES, 120, lines per frame
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cam_vsync  in  1  camera VSYNC, high during vertical blanking, already synchronized to clk
- cam_href  in  1  camera HREF, high while line bytes are valid, already synchronized
- cam_byte_en  in  1  one-cycle strobe: cam_data holds a valid byte
- cam_data  in  8  camera byte
- start  in  1  pulse; arm one capture (also clears sticky errors)
- continuous  in  1  level; when high, re-arm after every frame
- addr_in  out  AW  RAM write address
- data_in  out  DW  RAM write data
- regwrite  out  1  RAM write enable, one cycle per pixel
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- overflow  out  1  sticky: pixel arrived after H_PIX*V_LINES pixels
- line_err  out  1  sticky: a line ended with pixel count != H_PIX

## Operation
- States:
  - IDLE: if start or continuous is high, go to WAIT_VS.
  - WAIT_VS: wait for cam_vsync=1, then go to WAIT_FRAME.
  - WAIT_FRAME: wait for cam_vsync=0, then go to CAPTURE.
  - CAPTURE: on cam_vsync=1, go to DONE.
  - DONE: stays 1 cycle, then goes to WAIT_FRAME if continuous=1, else IDLE.
- Capture always starts at a frame boundary; arming mid-frame skips the rest of that frame.
- Byte phase:
  - Toggles on each cam_byte_en while cam_href=1 in CAPTURE.
  - Forced to 0 whenever cam_href=0.
  - Phase 0 byte is latched as hi; phase 1 byte (lo) completes the pixel.
- Pixel packing, RGB565 → RGB111:
  - R = hi[7], G = hi[2], B = lo[4].
  - data_in = {R,G,B}.
- Address:
  - Linear pixel counter starting at 0 for each frame; addr_in = count at write; count increments after each write.
  - Equivalent to row*H_PIX+col for well-formed frames.
- Counter limit:
  - When count == H_PIX*V_LINES, further completed pixels are not written (regwrite stays 0) and overflow sets.
  - The counter holds; there is no wrap-around into address 0.
- Line check:
  - A per-line pixel counter clears when cam_href=0.
  - On a cam_href falling edge in CAPTURE, if line count != H_PIX, line_err sets.
  - An odd trailing byte is discarded.
- Sticky flags (overflow, line_err) clear only on reset or on start accepted in IDLE.
- start while busy is ignored.
- Dropping continuous mid-frame finishes the current frame, then goes to IDLE.
- Bytes with cam_byte_en outside CAPTURE are ignored.
- In DONE and the WAIT states, count resets to 0.

## Timing
- Reset (async) forces:
  - state IDLE; addr_in=0, data_in=0, regwrite=0, busy=0, frame_done=0, overflow=0, line_err=0.
  - byte phase 0; all counters 0.
- All outputs are registered.
- Write latency:
  - regwrite, addr_in and data_in are valid together 1 cycle after the clk edge that samples the phase-1 cam_byte_en.
  - regwrite is high exactly 1 cycle per pixel.
  - addr_in/data_in hold their last values when regwrite=0.
- frame_done is high during the single DONE cycle, i.e. 1 cycle after the edge sampling cam_vsync=1 in CAPTURE.
- busy:
  - Rises 1 cycle after start/continuous is sampled in IDLE.
  - Falls on the cycle IDLE is re-entered.
- Flag timing: overflow and line_err assert 1 cycle after the causing edge.
- Simultaneous events:
  - A pixel completing on the same edge that samples cam_vsync=1 is still written, then CAPTURE exits.
  - start and rst together: rst wins.
- Minimum back-to-back cam_byte_en spacing is 1 cycle; full throughput is 1 pixel per 2 cycles.

## Test plan
- Reset mid-capture:
  - Stimulus: assert rst during CAPTURE with regwrite pending.
  - Response: all outputs 0 immediately, without waiting for a clk edge; after release, the block stays IDLE until start.
- Single-shot, full frame:
  - Stimulus: start, then one 4x2 frame (H_PIX=4, V_LINES=2 override) with byte pairs 0x80/0x10 → expect {1,0,1}=3'b101, and 0x04/0x00 → expect 3'b010.
  - Response: 8 writes at addresses 0..7, one frame_done, then busy=0, no flags.
- Continuous mode:
  - Stimulus: continuous=1 for 3 frames.
  - Response: 3 frame_done pulses; addresses restart at 0 each frame; busy stays 1.
- Overflow:
  - Stimulus: frame with 3 lines at H_PIX=4, V_LINES=2.
  - Response: writes stop after address 7; overflow=1; the next start clears it.
- Line error:
  - Stimulus: line of 3 pixels plus an odd byte.
  - Response: the odd byte is not written; line_err=1 after HREF falls; the next line continues at address 3.
- Arm mid-frame:
  - Stimulus: start while cam_vsync=0 in the middle of a frame.
  - Response: no writes until the next VSYNC high→low; then a full frame is captured from address 0.
